// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and default datapath widths.
package cpu_pkg;

    localparam int          PC_W        = 64;
    localparam int          INSTR_W     = 32;
    localparam logic [63:0] RESET_PC    = 64'h0;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, single-entry
// instruction buffer feeding IF/ID, branch redirect with stale-response drop.
module if_fetch_unit #(
    parameter int               PC_W        = cpu_pkg::PC_W,
    parameter int               INSTR_W     = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]  RESET_PC    = PC_W'(cpu_pkg::RESET_PC),
    parameter int               INSTR_BYTES = cpu_pkg::INSTR_BYTES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PCWrite,
    input  logic                Branch_taken,
    input  logic [PC_W-1:0]     Branch_target,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [PC_W-1:0]     PC_addr,
    output logic [INSTR_W-1:0]  Instruc,
    output logic                IFID_Write,
    output logic                Flush
);

    import cpu_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc, req_pc_d;
    logic            drop_q, drop_d;
    logic            valid_q, valid_d;
    logic            load_buf;
    logic [PC_W-1:0] target;
    logic            unused_tgt;

    assign target     = {Branch_target[PC_W-1:2], 2'b00};
    assign unused_tgt = ^Branch_target[1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc;
        drop_d   = drop_q;
        valid_d  = valid_q;
        load_buf = 1'b0;

        case (state_q)
            REQ: begin
                if (imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_W'(INSTR_BYTES);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        load_buf = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (PCWrite) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        // A redirect overrides everything above; an in-flight request becomes stale.
        if (Branch_taken) begin
            pc_d     = target;
            valid_d  = 1'b0;
            load_buf = 1'b0;
            case (state_q)
                REQ: begin
                    if (imem_ready) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            PC_addr <= '0;
            Instruc <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            if (load_buf) begin
                PC_addr <= req_pc;
                Instruc <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        req_pc <= req_pc_d;
    end

    assign imem_req   = (state_q == REQ) && !reset;
    assign imem_addr  = pc_q;
    assign IFID_Write = valid_q && PCWrite && !Branch_taken;
    // Second term inserts a bubble when the pipeline advances with nothing buffered.
    assign Flush      = !reset && (Branch_taken || (PCWrite && !valid_q));

    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (state_q == WAIT))
        else $error("imem_rvalid asserted outside WAIT");

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small variable-latency memory model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCWrite = 1'b1;
    logic        Branch_taken = 1'b0;
    logic [63:0] Branch_target = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] PC_addr;
    logic [31:0] Instruc;
    logic        IFID_Write;
    logic        Flush;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .Branch_taken (Branch_taken),
        .Branch_target(Branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .PC_addr      (PC_addr),
        .Instruc      (Instruc),
        .IFID_Write   (IFID_Write),
        .Flush        (Flush)
    );

    always #5 clk = ~clk;

    // Memory model: one pending request, response after lat cycles.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h0050_0093;
            64'h4:   return 32'h00A0_0113;
            64'h8:   return 32'h00F0_0193;
            64'hC:   return 32'hDEAD_BEEF;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    int          lat = 1;
    logic        pend;
    int          cnt;
    logic [63:0] paddr;

    assign imem_rvalid = pend && (cnt == 0);
    assign imem_rdata  = imem_rvalid ? mem_word(paddr) : 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= '0;
        end else if (imem_req && imem_ready) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= imem_addr;
        end else if (pend && cnt == 0) begin
            pend <= 1'b0;
        end else if (pend) begin
            cnt <= cnt - 1;
        end
    end

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic ifid, input logic fl);
        expect_eq({tag, ".req"},   64'(imem_req),   64'(req));
        expect_eq({tag, ".ifid"},  64'(IFID_Write), 64'(ifid));
        expect_eq({tag, ".flush"}, 64'(Flush),      64'(fl));
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk_ctl("rst", 1'b0, 1'b0, 1'b0);
        expect_eq("rst.pc_addr", PC_addr, 64'h0);
        expect_eq("rst.instr", 64'(Instruc), 64'h0);

        // Cycle 0: release reset, latency 1, PCWrite=1
        reset = 1'b0; #1;
        chk_ctl("c0", 1'b1, 1'b0, 1'b1);
        expect_eq("c0.addr", imem_addr, 64'h0);
        tick(); chk_ctl("c1", 1'b0, 1'b0, 1'b1);
        tick(); chk_ctl("c2", 1'b0, 1'b1, 1'b0);
        expect_eq("c2.pc_addr", PC_addr, 64'h0);
        expect_eq("c2.instr", 64'(Instruc), 64'h0050_0093);
        tick(); chk_ctl("c3", 1'b1, 1'b0, 1'b1);
        expect_eq("c3.addr", imem_addr, 64'h4);
        tick(); chk_ctl("c4", 1'b0, 1'b0, 1'b1);
        tick(); chk_ctl("c5", 1'b0, 1'b1, 1'b0);
        expect_eq("c5.pc_addr", PC_addr, 64'h4);
        expect_eq("c5.instr", 64'(Instruc), 64'h00A0_0113);
        tick(); chk_ctl("c6", 1'b1, 1'b0, 1'b1);
        expect_eq("c6.addr", imem_addr, 64'h8);

        // Stall in HOLD for 5 cycles
        tick(); PCWrite = 1'b0; #1;
        chk_ctl("c7", 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk_ctl("stall", 1'b0, 1'b0, 1'b0);
            expect_eq("stall.pc_addr", PC_addr, 64'h8);
            expect_eq("stall.instr", 64'(Instruc), 64'h00F0_0193);
        end
        tick(); PCWrite = 1'b1; #1;
        chk_ctl("c13", 1'b0, 1'b1, 1'b0);
        expect_eq("c13.pc_addr", PC_addr, 64'h8);
        tick(); lat = 4; #1;
        chk_ctl("c14", 1'b1, 1'b0, 1'b1);
        expect_eq("c14.addr", imem_addr, 64'hC);

        // Branch in WAIT, stale 0xDEADBEEF arrives later
        tick(); Branch_taken = 1'b1; Branch_target = 64'h100; #1;
        chk_ctl("c15", 1'b0, 1'b0, 1'b1);
        tick(); Branch_taken = 1'b0; lat = 1; #1;
        chk_ctl("c16", 1'b0, 1'b0, 1'b1);
        tick(); chk_ctl("c17", 1'b0, 1'b0, 1'b1);
        tick(); chk_ctl("c18", 1'b0, 1'b0, 1'b1);
        expect_eq("c18.rvalid", 64'(imem_rvalid), 64'h1);
        tick(); chk_ctl("c19", 1'b1, 1'b0, 1'b1);
        expect_eq("c19.addr", imem_addr, 64'h100);
        tick(); chk_ctl("c20", 1'b0, 1'b0, 1'b1);
        tick(); chk_ctl("c21", 1'b0, 1'b1, 1'b0);
        expect_eq("c21.pc_addr", PC_addr, 64'h100);
        expect_eq("c21.instr", 64'(Instruc), 64'hC0DE_0100);

        // Branch coincident with imem_ready in REQ, unaligned target
        tick(); Branch_taken = 1'b1; Branch_target = 64'h203; #1;
        chk_ctl("c22", 1'b1, 1'b0, 1'b1);
        expect_eq("c22.addr", imem_addr, 64'h104);
        tick(); Branch_taken = 1'b0; #1;
        chk_ctl("c23", 1'b0, 1'b0, 1'b1);
        tick(); chk_ctl("c24", 1'b1, 1'b0, 1'b1);
        expect_eq("c24.addr", imem_addr, 64'h200);
        tick(); chk_ctl("c25", 1'b0, 1'b0, 1'b1);
        tick(); chk_ctl("c26", 1'b0, 1'b1, 1'b0);
        expect_eq("c26.pc_addr", PC_addr, 64'h200);
        expect_eq("c26.instr", 64'(Instruc), 64'hC0DE_0200);
        tick(); chk_ctl("c27", 1'b1, 1'b0, 1'b1);
        expect_eq("c27.addr", imem_addr, 64'h204);
        tick();

        // Branch in HOLD while stalled
        tick(); PCWrite = 1'b0; #1;
        chk_ctl("c29", 1'b0, 1'b0, 1'b0);
        expect_eq("c29.pc_addr", PC_addr, 64'h204);
        tick(); Branch_taken = 1'b1; Branch_target = 64'h300; #1;
        chk_ctl("c30", 1'b0, 1'b0, 1'b1);
        tick(); Branch_taken = 1'b0; lat = 4; #1;
        chk_ctl("c31", 1'b1, 1'b0, 1'b0);
        expect_eq("c31.addr", imem_addr, 64'h300);

        // Asynchronous reset in WAIT, held 2 cycles
        tick(); PCWrite = 1'b1; reset = 1'b1; lat = 1; #1;
        chk_ctl("c32", 1'b0, 1'b0, 1'b0);
        expect_eq("c32.pc_addr", PC_addr, 64'h0);
        expect_eq("c32.instr", 64'(Instruc), 64'h0);
        tick(); chk_ctl("c33", 1'b0, 1'b0, 1'b0);
        tick(); reset = 1'b0; #1;
        chk_ctl("c34", 1'b1, 1'b0, 1'b1);
        expect_eq("c34.addr", imem_addr, 64'h0);
        tick(); chk_ctl("c35", 1'b0, 1'b0, 1'b1);
        tick(); chk_ctl("c36", 1'b0, 1'b1, 1'b0);
        expect_eq("c36.pc_addr", PC_addr, 64'h0);
        expect_eq("c36.instr", 64'(Instruc), 64'h0050_0093);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
